asic_ioanalog_sw: RTL and testbench

Parametrised successor of the single analog pad cell: a bank of NCH analog pads, each with a transmission-gate switch enable. A core-side valid/ready request selects which pads connect to the analog bus. The block sequences every change break-before-make with programmable break and settle intervals. It forces all switches open while IO power is not good. Supplies and the control ring pass straight through the cell.

---
 rtl/asic_ioanalog_sw.sv | 182 ++++++++++++++++++
 tb/tb_asic_ioanalog_sw.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_ioanalog_sw.sv
// Analog pad bank switch controller: break-before-make sequencing of NCH
// transmission-gate enables, gated by IO power good. Supply/pad/ring ports are pure feedthrough.
module asic_ioanalog_sw #(
    parameter string TYPE  = "SOFT",
    parameter string DIR   = "N",
    parameter int    NCH   = 4,
    parameter int    NCTRL = 8,
    parameter int    CW    = 4,
    parameter string MODE  = "ONEHOT"
) (
    input  logic             clk,
    input  logic             nreset,
    inout  wire  [NCH-1:0]   pad,
    inout  wire              vddio,
    inout  wire              vssio,
    inout  wire              vdd,
    inout  wire              vss,
    inout  wire  [NCTRL-1:0] ctrlring,
    input  logic             pwr_ok,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [NCH-1:0]   req_sel,
    input  logic [CW-1:0]    bbm_cycles,
    input  logic [CW-1:0]    settle_cycles,
    input  logic             err_clr,
    output logic [NCH-1:0]   sw_en,
    output logic [NCH-1:0]   sel_active,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_BREAK  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [NCH-1:0] ZERO_SEL = {NCH{1'b0}};
    localparam logic [NCH-1:0] ONE_SEL  = NCH'(1'b1);
    localparam logic [CW-1:0]  ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1'b1);
    localparam bit             IS_ONEHOT = (MODE == "ONEHOT");

    // More than one bit set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_hot(input logic [NCH-1:0] v);
        multi_hot = |(v & (v - ONE_SEL));
    endfunction

    state_t         state_r, state_s;
    logic [NCH-1:0] sel_q_r, sel_q_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [CW-1:0]  settle_q_r, settle_q_s;
    logic [NCH-1:0] sw_en_r, sw_en_s;
    logic [NCH-1:0] sel_active_r, sel_active_s;
    logic           done_r, done_s;
    logic           abort_r, abort_s;
    logic           err_r, err_s;
    logic           busy_r, busy_s;
    logic           ready_s;
    logic           accept_s;
    logic           illegal_s;

    assign ready_s   = (state_r == ST_IDLE) & pwr_ok;
    assign accept_s  = req_valid & ready_s;
    assign illegal_s = IS_ONEHOT & multi_hot(req_sel);

    // Next-state and next-output logic for the switch sequencer.
    always_comb begin
        state_s      = state_r;
        sel_q_s      = sel_q_r;
        cnt_s        = cnt_r;
        settle_q_s   = settle_q_r;
        sw_en_s      = sw_en_r;
        sel_active_s = sel_active_r;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end

        if (!pwr_ok) begin
            // Losing IO power opens every switch regardless of what was in flight.
            sw_en_s      = ZERO_SEL;
            sel_active_s = ZERO_SEL;
            state_s      = ST_OFF;
            if ((state_r == ST_BREAK) || (state_r == ST_SETTLE)) begin
                abort_s = 1'b1;
            end else begin
                abort_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_s = ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            err_s = 1'b1;
                        end else if (req_sel == sel_active_r) begin
                            done_s = 1'b1;
                        end else begin
                            sel_q_s    = req_sel;
                            cnt_s      = bbm_cycles;
                            settle_q_s = settle_cycles;
                            sw_en_s    = ZERO_SEL;
                            state_s    = ST_BREAK;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (cnt_r == ZERO_CNT) begin
                        sw_en_s = sel_q_r;
                        cnt_s   = settle_q_r;
                        state_s = ST_SETTLE;
                    end else begin
                        cnt_s = cnt_r - ONE_CNT;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == ZERO_CNT) begin
                        sel_active_s = sel_q_r;
                        done_s       = 1'b1;
                        state_s      = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r - ONE_CNT;
                    end
                end
                default: begin
                    sw_en_s      = ZERO_SEL;
                    sel_active_s = ZERO_SEL;
                    state_s      = ST_OFF;
                end
            endcase
        end

        busy_s = (state_s == ST_BREAK) || (state_s == ST_SETTLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r      <= ST_OFF;
            sel_q_r      <= ZERO_SEL;
            cnt_r        <= ZERO_CNT;
            settle_q_r   <= ZERO_CNT;
            sw_en_r      <= ZERO_SEL;
            sel_active_r <= ZERO_SEL;
            done_r       <= 1'b0;
            abort_r      <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_q_r      <= sel_q_s;
            cnt_r        <= cnt_s;
            settle_q_r   <= settle_q_s;
            sw_en_r      <= sw_en_s;
            sel_active_r <= sel_active_s;
            done_r       <= done_s;
            abort_r      <= abort_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
        end
    end

    assign req_ready  = ready_s;
    assign sw_en      = sw_en_r;
    assign sel_active = sel_active_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign abort      = abort_r;
    assign err        = err_r;

endmodule

// File: tb/tb_asic_ioanalog_sw.sv
// Bench for asic_ioanalog_sw: completion/abort events are checked against a
// queue of expected results by an independent monitor; sequencing timing is checked inline.
module tb_asic_ioanalog_sw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nreset, pwr_ok, req_valid, err_clr, req_valid_m;
    logic [3:0] req_sel, bbm_cycles, settle_cycles, req_sel_m;

    wire  [3:0] pad, pad_m;
    wire        vddio, vssio, vdd, vss;
    wire  [7:0] ctrlring;

    logic       req_ready, busy, done, abort, err;
    logic [3:0] sw_en, sel_active;
    logic       req_ready_m, busy_m, done_m, abort_m, err_m;
    logic [3:0] sw_en_m, sel_active_m;

    asic_ioanalog_sw #(.NCH(4), .NCTRL(8), .CW(4), .MODE("ONEHOT")) dut (
        .clk(clk), .nreset(nreset), .pad(pad), .vddio(vddio), .vssio(vssio),
        .vdd(vdd), .vss(vss), .ctrlring(ctrlring), .pwr_ok(pwr_ok),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .bbm_cycles(bbm_cycles), .settle_cycles(settle_cycles), .err_clr(err_clr),
        .sw_en(sw_en), .sel_active(sel_active), .busy(busy), .done(done),
        .abort(abort), .err(err)
    );

    asic_ioanalog_sw #(.NCH(4), .NCTRL(8), .CW(4), .MODE("MULTI")) dut_m (
        .clk(clk), .nreset(nreset), .pad(pad_m), .vddio(vddio), .vssio(vssio),
        .vdd(vdd), .vss(vss), .ctrlring(ctrlring), .pwr_ok(pwr_ok),
        .req_valid(req_valid_m), .req_ready(req_ready_m), .req_sel(req_sel_m),
        .bbm_cycles(bbm_cycles), .settle_cycles(settle_cycles), .err_clr(err_clr),
        .sw_en(sw_en_m), .sel_active(sel_active_m), .busy(busy_m), .done(done_m),
        .abort(abort_m), .err(err_m)
    );

    typedef struct packed {
        logic       is_abort;
        logic [3:0] sw;
        logic [3:0] act;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_abort, input logic [3:0] sw, input logic [3:0] act);
        exp_t e;
        e.is_abort = is_abort;
        e.sw       = sw;
        e.act      = act;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sel, input logic [3:0] b, input logic [3:0] s);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_sel       = sel;
        bbm_cycles    = b;
        settle_cycles = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic count_zero(output int n);
        n = 0;
        while (sw_en == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    // Monitor: pops an expectation on every done/abort pulse and watches for make-before-break.
    initial begin
        exp_t       e;
        logic [3:0] prev_sw;
        prev_sw = 4'b0000;
        forever begin
            @(negedge clk);
            if (nreset !== 1'b1) begin
                prev_sw = 4'b0000;
            end else begin
                if (done === 1'b1 || abort === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: done=%0b abort=%0b with empty queue", done, abort);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_kind_abort", 32'(abort), 32'(e.is_abort));
                        check("evt_done", 32'(done), 32'(!e.is_abort));
                        check("evt_sw_en", 32'(sw_en), 32'(e.sw));
                        check("evt_sel_active", 32'(sel_active), 32'(e.act));
                    end
                end
                if (sw_en !== prev_sw) begin
                    checks++;
                    if (prev_sw != 4'b0000 && sw_en != 4'b0000) begin
                        errors++;
                        $display("FAIL bbm_glitch: sw_en went %b -> %b without a break", prev_sw, sw_en);
                    end
                end
                prev_sw = sw_en;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nreset = 1'b0; pwr_ok = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
        req_sel = 4'b0000; bbm_cycles = 4'd0; settle_cycles = 4'd0;
        req_valid_m = 1'b0; req_sel_m = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({sw_en, sel_active, busy, done, abort, err, req_ready}), 32'd0);

        // Power-up: OFF until pwr_ok, then IDLE with ready.
        nreset = 1'b1;
        tick();
        check("off_no_ready", 32'(req_ready), 32'd0);
        pwr_ok = 1'b1;
        check("ready_still_off", 32'(req_ready), 32'd0);
        tick();
        check("ready_in_idle", 32'(req_ready), 32'd1);
        check("idle_sw_en", 32'(sw_en), 32'd0);

        // MULTI build accepts a multi-hot selection.
        req_valid_m = 1'b1; req_sel_m = 4'b1011; bbm_cycles = 4'd1; settle_cycles = 4'd0;
        tick();
        req_valid_m = 1'b0;
        n = 0;
        while (sw_en_m == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        check("multi_break_len", 32'(n), 32'd2);
        check("multi_sw_en", 32'(sw_en_m), 32'hb);
        check("multi_err", 32'(err_m), 32'd0);
        tick();
        check("multi_done", 32'(done_m), 32'd1);
        check("multi_sel_active", 32'(sel_active_m), 32'hb);

        // First selection: bbm=2, settle=3.
        push(1'b0, 4'b0010, 4'b0010);
        send(4'b0010, 4'd2, 4'd3);
        count_zero(n);
        check("t1_break_len", 32'(n), 32'd3);
        check("t1_sw_en", 32'(sw_en), 32'h2);
        wait_done(n);
        check("t1_settle_len", 32'(n), 32'd4);

        // Switch 0010 -> 0100 with minimum intervals.
        push(1'b0, 4'b0100, 4'b0100);
        send(4'b0100, 4'd0, 4'd0);
        count_zero(n);
        check("t2_break_len", 32'(n), 32'd1);
        check("t2_sw_en", 32'(sw_en), 32'h4);
        wait_done(n);
        check("t2_settle_len", 32'(n), 32'd1);

        // Illegal ONEHOT request: err only.
        send(4'b0011, 4'd1, 4'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_sw_en", 32'(sw_en), 32'h4);
        check("ill_sel_active", 32'(sel_active), 32'h4);
        check("ill_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Clear coinciding with a new illegal request: set wins.
        err_clr = 1'b1;
        send(4'b1100, 4'd0, 4'd0);
        err_clr = 1'b0;
        check("err_set_wins", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared2", 32'(err), 32'd0);

        // Repeat of current selection completes at once.
        push(1'b0, 4'b0100, 4'b0100);
        send(4'b0100, 4'd3, 4'd3);
        check("rep_done", 32'(done), 32'd1);
        check("rep_busy", 32'(busy), 32'd0);
        check("rep_sw_en", 32'(sw_en), 32'h4);
        tick();

        // Empty selection: break all, settle open.
        push(1'b0, 4'b0000, 4'b0000);
        send(4'b0000, 4'd1, 4'd0);
        wait_done(n);
        check("zero_sel_len", 32'(n), 32'd3);
        tick();

        push(1'b0, 4'b0010, 4'b0010);
        send(4'b0010, 4'd0, 4'd0);
        wait_done(n);
        check("restore_len", 32'(n), 32'd2);
        tick();

        // Power loss during SETTLE aborts.
        push(1'b1, 4'b0000, 4'b0000);
        send(4'b0100, 4'd1, 4'd5);
        count_zero(n);
        check("ab_break_len", 32'(n), 32'd2);
        check("ab_sw_en_settle", 32'(sw_en), 32'h4);
        check("ab_busy_settle", 32'(busy), 32'd1);
        tick();
        pwr_ok = 1'b0;
        tick();
        check("ab_abort", 32'(abort), 32'd1);
        check("ab_sw_en", 32'(sw_en), 32'd0);
        check("ab_sel_active", 32'(sel_active), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        tick();
        check("ab_abort_pulse", 32'(abort), 32'd0);
        repeat (3) tick();
        check("ab_off_ready", 32'(req_ready), 32'd0);
        pwr_ok = 1'b1;
        tick();
        check("ab_idle_ready", 32'(req_ready), 32'd1);
        check("ab_idle_sw_en", 32'(sw_en), 32'd0);

        // Async reset in the middle of BREAK.
        push(1'b0, 4'b0001, 4'b0001);
        send(4'b0001, 4'd0, 4'd0);
        wait_done(n);
        check("pre_rst_len", 32'(n), 32'd2);
        tick();
        send(4'b0010, 4'd5, 4'd0);
        check("rst_busy_before", 32'(busy), 32'd1);
        check("rst_active_before", 32'(sel_active), 32'h1);
        #2;
        nreset = 1'b0;
        #1;
        check("rst_mid_break", 32'({sw_en, sel_active, busy, done, abort, err, req_ready}), 32'd0);
        tick();
        nreset = 1'b1;
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
